// File: rtl/coin_pkg.sv
// coin_pkg -- shared definitions for the coin acceptor slice.
//   coin_t     : coin codes driven to the newspaper_seller `in` port
//   CNT_W      : width of the per-channel debounce counter
//   TOTAL_MAX  : saturation value of the optional running total
//   sat_add    : saturating 8-bit add used by the running total
// Optional feature macro used by this slice: COIN_TOTAL_EN.
`timescale 1ns / 1ps

package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_t;

  localparam int CNT_W     = 8;
  localparam int TOTAL_MAX = 255;

  // Adds a small increment to an 8-bit total and clamps at the top value
  // instead of wrapping back to zero.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'(TOTAL_MAX) : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce -- one sensor channel: 2-flop synchronizer, debounce
// counter, rising-edge detect and a pending-event flag.
// Ports:
//   clk   in  clock, all state on rising edge
//   rst   in  asynchronous active-high reset
//   raw   in  raw bouncing sensor input (asynchronous)
//   clr   in  arbiter has consumed the pending event this cycle
//   pend  out a debounced coin arrival is waiting to be reported
// Parameter DB_CYCLES (2..255): consecutive differing cycles before the
// debounced level is allowed to change.
`timescale 1ns / 1ps

module coin_debounce
  import coin_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic clr,
  output logic pend
);

  // The counter is compared one short of DB_CYCLES so that the toggle
  // happens on the edge that completes the DB_CYCLES-th differing cycle.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize the raw input, then accept a level change only after the
  // synchronized value has disagreed with the debounced level long enough.
  // A 0->1 debounced change raises pend one edge later; a fresh rise has
  // priority over the arbiter's clear so no arrival can be dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pend    <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;

      if (sync2 != level) begin
        if (cnt == DB_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end

      if (level && !level_d) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor -- debounces the 5-jiao and 1-yuan sensors and emits a
// one-cycle registered coin code per accepted coin.
// Ports:
//   clk         in  clock
//   rst         in  asynchronous active-high reset
//   coin5_raw   in  raw 5-jiao sensor
//   coin10_raw  in  raw 1-yuan sensor
//   coin[1:0]   out 00 none, 01 5 jiao, 10 1 yuan (one cycle per coin)
//   total[7:0]  out running value in 5-jiao units, saturating at 255
//                   (only when macro COIN_TOTAL_EN is defined)
// Parameter DB_CYCLES (2..255): debounce length in cycles.
`timescale 1ns / 1ps

module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
`ifdef COIN_TOTAL_EN
  output logic [7:0] total,
`endif
  output logic [1:0] coin
);

  logic pend5;
  logic pend10;
  logic take5;
  logic take10;

  // 1 yuan wins a tie; the 5-jiao event stays pending and goes out on
  // the following cycle.
  assign take10 = pend10;
  assign take5  = pend5 & ~pend10;

  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db5 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin5_raw),
    .clr  (take5),
    .pend (pend5)
  );

  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db10 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin10_raw),
    .clr  (take10),
    .pend (pend10)
  );

  // Registered coin code: one cycle per consumed pending event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin <= COIN_NONE;
    end else if (take10) begin
      coin <= COIN_10;
    end else if (take5) begin
      coin <= COIN_5;
    end else begin
      coin <= COIN_NONE;
    end
  end

`ifdef COIN_TOTAL_EN
  // Running total updated on the same edge the coin code is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total <= '0;
    end else if (take10) begin
      total <= sat_add(total, 2'd2);
    end else if (take5) begin
      total <= sat_add(total, 2'd1);
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor -- directed and randomized bench for coin_acceptor.
// Expected coin codes come from a behavioural model based on run lengths
// of sampled sensor values and per-channel ready times. The total port is
// checked when macro COIN_TOTAL_EN is defined.
`timescale 1ns / 1ps

module tb_coin_acceptor;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic       coin5Raw;
  logic       coin10Raw;
  logic [1:0] coin;
`ifdef COIN_TOTAL_EN
  logic [7:0] total;
`endif

  coin_acceptor #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5Raw),
    .coin10_raw (coin10Raw),
`ifdef COIN_TOTAL_EN
    .total      (total),
`endif
    .coin       (coin)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state; index 0 = 5 jiao, index 1 = 1 yuan.
  bit         lvl[2];
  int         runLen[2];
  int         readyAt[2];
  int         edgeNum;
  logic [1:0] expCoin;
  int         expTotal;

  // Observation bookkeeping for per-scenario checks.
  int pulse5Seen;
  int pulse10Seen;
  int scenCycle;
  int firstPulse;

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      lvl[c]     = 1'b0;
      runLen[c]  = 0;
      readyAt[c] = -1;
    end
    edgeNum  = 0;
    expCoin  = 2'b00;
    expTotal = 0;
  endtask

  // One rising edge: report an arrival whose ready time has come (1 yuan
  // first), then account the sensor values sampled on this edge. A level
  // counts as accepted after DB equal samples against the current level;
  // the coin code appears 4 edges after the last of those samples.
  task automatic modelStep(input bit r5, input bit r10);
    bit r[2];
    r[0] = r5;
    r[1] = r10;
    edgeNum++;
    expCoin = 2'b00;
    if (readyAt[1] >= 0 && readyAt[1] <= edgeNum) begin
      expCoin    = 2'b10;
      readyAt[1] = -1;
      expTotal   = (expTotal + 2 > 255) ? 255 : expTotal + 2;
    end else if (readyAt[0] >= 0 && readyAt[0] <= edgeNum) begin
      expCoin    = 2'b01;
      readyAt[0] = -1;
      expTotal   = (expTotal + 1 > 255) ? 255 : expTotal + 1;
    end
    for (int c = 0; c < 2; c++) begin
      if (r[c] != lvl[c]) begin
        runLen[c]++;
        if (runLen[c] == DB) begin
          lvl[c]    = r[c];
          runLen[c] = 0;
          if (r[c]) readyAt[c] = edgeNum + 4;
        end
      end else begin
        runLen[c] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (coin === expCoin)
    else begin
      errors++;
      $error("[TB] FAIL %s coin observed=%b expected=%b (edge %0d)", tag, coin, expCoin, edgeNum);
    end
`ifdef COIN_TOTAL_EN
    checks++;
    assert (total === 8'(expTotal))
    else begin
      errors++;
      $error("[TB] FAIL %s_total observed=%0d expected=%0d", tag, total, expTotal);
    end
`endif
    if (coin == 2'b01) pulse5Seen++;
    if (coin == 2'b10) pulse10Seen++;
    if (coin != 2'b00 && firstPulse < 0) firstPulse = scenCycle;
  endtask

  // Called just after a falling edge: drive, let one rising edge happen,
  // then compare on the following falling edge.
  task automatic applyStimulus(input bit c5, input bit c10, input string tag);
    coin5Raw  = c5;
    coin10Raw = c10;
    @(posedge clk);
    scenCycle++;
    modelStep(c5, c10);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic holdCycles(input bit c5, input bit c10, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(c5, c10, tag);
  endtask

  task automatic startScenario();
    pulse5Seen  = 0;
    pulse10Seen = 0;
    scenCycle   = 0;
    firstPulse  = -1;
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Short asynchronous reset pulse placed between clock edges; the coin
  // output must clear while reset is still high.
  task automatic pulseReset(input string tag);
    rst = 1'b1;
    #0.15;
    checkCount({tag, "_coin_in_reset"}, int'(coin), 0);
`ifdef COIN_TOTAL_EN
    checkCount({tag, "_total_in_reset"}, int'(total), 0);
`endif
    #0.15;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int rem5;
    int rem10;
    bit lvl5;
    bit lvl10;

    rst       = 1'b1;
    coin5Raw  = 1'b0;
    coin10Raw = 1'b0;
    modelReset();
    startScenario();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCount("reset_coin", int'(coin), 0);
`ifdef COIN_TOTAL_EN
    checkCount("reset_total", int'(total), 0);
`endif
    rst = 1'b0;
    $display("[TB] reset released");

    // Short 3-cycle pulse is rejected.
    startScenario();
    holdCycles(1'b1, 1'b0, 3, "short5");
    holdCycles(1'b0, 1'b0, 10, "short5_low");
    checkCount("short5_pulses", pulse5Seen, 0);

    // Steady 5-jiao coin: one pulse, DB+4 edges after first sample.
    startScenario();
    holdCycles(1'b1, 1'b0, 12, "single5");
    holdCycles(1'b0, 1'b0, 10, "single5_low");
    checkCount("single5_pulses", pulse5Seen, 1);
    checkCount("single5_latency", firstPulse, DB + 4);
`ifdef COIN_TOTAL_EN
    checkCount("single5_total", int'(total), 1);
`endif

    // Simultaneous coins: 1 yuan then 5 jiao on consecutive cycles.
    startScenario();
    holdCycles(1'b1, 1'b1, 10, "both");
    holdCycles(1'b0, 1'b0, 10, "both_low");
    checkCount("both_p10", pulse10Seen, 1);
    checkCount("both_p5", pulse5Seen, 1);
    checkCount("both_first", firstPulse, DB + 4);
`ifdef COIN_TOTAL_EN
    checkCount("both_total", int'(total), 4);
`endif

    // Bouncing 1-yuan sensor followed by a stable interval.
    startScenario();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'(i % 2 == 0), "bounce");
    holdCycles(1'b0, 1'b1, 10, "bounce_stable");
    holdCycles(1'b0, 1'b0, 10, "bounce_low");
    checkCount("bounce_pulses", pulse10Seen, 1);
    checkCount("bounce_after_stable", int'(firstPulse > 20), 1);

    // Reset mid-count, then reset with the 1-yuan event pending.
    startScenario();
    holdCycles(1'b0, 1'b1, 5, "rst_midcount");
    pulseReset("rst_midcount");
    holdCycles(1'b0, 1'b0, 12, "rst_midcount_low");
    holdCycles(1'b0, 1'b1, 7, "rst_pending");
    pulseReset("rst_pending");
    holdCycles(1'b0, 1'b0, 12, "rst_pending_low");
    checkCount("rst_discard_pulses", pulse10Seen, 0);

    // Sensor already high across reset is accepted as a new coin.
    startScenario();
    holdCycles(1'b0, 1'b1, 3, "rst_high");
    pulseReset("rst_high");
    holdCycles(1'b0, 1'b1, 12, "rst_high_hold");
    holdCycles(1'b0, 1'b0, 6, "rst_high_low");
    checkCount("rst_high_pulses", pulse10Seen, 1);

    // Randomized hold lengths on both channels.
    startScenario();
    rem5  = 0;
    rem10 = 0;
    lvl5  = 1'b0;
    lvl10 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rem5 == 0) begin
        lvl5 = 1'($urandom_range(0, 1));
        rem5 = $urandom_range(1, 7);
      end
      if (rem10 == 0) begin
        lvl10 = 1'($urandom_range(0, 1));
        rem10 = $urandom_range(1, 7);
      end
      rem5--;
      rem10--;
      applyStimulus(lvl5, lvl10, "random");
    end
    holdCycles(1'b0, 1'b0, 10, "random_drain");

    // 130 one-yuan coins: total saturates at 255.
    pulseReset("sat");
    startScenario();
    for (int i = 0; i < 130; i++) begin
      holdCycles(1'b0, 1'b1, 5, "sat_high");
      holdCycles(1'b0, 1'b0, 5, "sat_low");
    end
    holdCycles(1'b0, 1'b0, 6, "sat_drain");
    checkCount("sat_pulses", pulse10Seen, 130);
`ifdef COIN_TOTAL_EN
    checkCount("sat_total", int'(total), 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles required before a debounced level change is accepted; legal range 2..255.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port coin5_raw  input  1  raw, asynchronous, bouncing 5-jiao coin sensor; high = coin present.
REQ-005 Port coin10_raw  input  1  raw, asynchronous, bouncing 1-yuan coin sensor; high = coin present.
REQ-006 Port coin  output  2  registered coin code to the downstream newspaper_seller `in` port: 2'b00 none, 2'b01 5 jiao, 2'b10 1 yuan; 2'b11 never driven.
REQ-007 Port total  output  8  (present only with COIN_TOTAL_EN) running inserted value in 5-jiao units.

Function
REQ-008 Each raw input SHALL pass through a 2-flip-flop synchronizer before any other logic uses it.
REQ-009 Per channel: a debounced level register and a counter; the counter increments while the synchronized input differs from the debounced level and clears to 0 on any cycle the two are equal.
REQ-010 When the counter reaches DB_CYCLES, the debounced level SHALL toggle and the counter SHALL clear in the same edge.
REQ-011 A 0->1 transition of a debounced level SHALL set that channel's pending flag on the next edge; 1->0 transitions produce no event.
REQ-012 Output arbitration per edge: pend10 set -> coin=2'b10 and pend10 cleared; else pend5 set -> coin=2'b01 and pend5 cleared; else coin=2'b00.
REQ-013 coin SHALL be high for exactly one cycle per accepted coin; back-to-back events are two consecutive one-cycle codes.
REQ-014 Simultaneous debounced rising edges on both channels SHALL yield 2'b10 in cycle N and 2'b01 in cycle N+1; neither coin is lost.
REQ-015 Latency: with raw input held steady high, coin is asserted exactly DB_CYCLES+4 rising edges after the first edge that samples the raw input high.
REQ-016 A raw pulse whose synchronized width is shorter than DB_CYCLES cycles SHALL produce no event.
REQ-017 A new coin on a channel SHALL require a debounced release (1->0) before the next acceptance; holding the sensor high yields exactly one event.

Reset
REQ-018 rst high SHALL immediately clear synchronizers, counters, debounced levels, pending flags, coin (2'b00) and total (0), independent of clk.
REQ-019 Reset asserted while an event is pending or a debounce count is in progress SHALL discard it; no event is emitted after release.
REQ-020 After rst deassertion, an input already high SHALL be debounced and accepted as a new coin.

Configuration
REQ-021 Macro COIN_TOTAL_EN defined: total port exists and increments by 1 per 2'b01 output and by 2 per 2'b10 output, saturating at 255.
REQ-022 Macro COIN_TOTAL_EN undefined: total port and its counter are absent; all other behaviour is identical.

Structure
REQ-023 Package coin_pkg SHALL hold coin codes COIN_NONE, COIN_5, COIN_10, and the debounce counter width constant (8).
REQ-024 Sub-module coin_debounce (synchronizer, debounce counter, rising-edge detect, pending flag) SHALL be instantiated once per channel; arbitration and total stay in coin_acceptor.

Verification (DB_CYCLES=4, clock period 2 ns)
REQ-025 coin5_raw high 3 cycles then low -> coin stays 2'b00 throughout.
REQ-026 coin5_raw high 12 cycles -> exactly one coin=2'b01 pulse, 8 edges after first sampling edge; total=1.
REQ-027 coin5_raw and coin10_raw rise same cycle, held 10 cycles -> coin=2'b10 then 2'b01 on consecutive cycles; total=3.
REQ-028 coin10_raw toggling every cycle for 20 cycles (bounce), then stable high 10 cycles -> one 2'b10 pulse only after stable interval.
REQ-029 rst pulsed 0.3 ns mid-count (counter=3) and again with pend10 set -> coin 2'b00 immediately, no pulse afterwards until a new debounced rise.
REQ-030 130 one-yuan coins with COIN_TOTAL_EN -> total saturates at 255 and holds.
